// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, data port and memory port of the
// shared-memory arbiter, plus its stall/error status outputs.
//   slave  : arbiter view (requests and mem_rdata in; ready/rdata/mem_* out)
//   master : environment view (requesters and memory model)
interface mem_arbiter_if;
  localparam int unsigned DATA_W = 32;

  // Fetch port
  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;

  // Data port
  logic              dm_rd;
  logic              dm_wr;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic [DATA_W-1:0] dm_rdata;

  // Memory port
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Status
  logic              stall_if;
  logic              stall_mem;
  logic              protocol_err;

  modport slave (
    input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata,
    output if_ready, if_rdata, dm_ready, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, protocol_err
  );

  modport master (
    output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata,
    input  if_ready, if_rdata, dm_ready, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, protocol_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a single-ported memory between an instruction-fetch
// requester and a data (load/store) requester. Data has priority, but a fetch
// that has waited through MAX_STREAK consecutive data grants wins next.
// Ports:
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-high
//   bus    : mem_arbiter_if.slave (fetch port, data port, memory port,
//            stall_if/stall_mem combinational stalls, sticky protocol_err)
module mem_arbiter #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  streak_q, streak_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              perr_q, perr_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic              data_req;
  logic              fetch_wins;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      cnt_q      <= '0;
      streak_q   <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      perr_q     <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      perr_q     <= perr_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      if_ready_q <= if_ready_d;
      dm_ready_q <= dm_ready_d;
    end
  end

  // Arbitration, sequencing and next values of the registered outputs
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    perr_d     = perr_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    if_ready_d = 1'b0;
    dm_ready_d = 1'b0;

    data_req   = bus.dm_rd | bus.dm_wr;
    // Fetch takes the slot when alone, or when data has starved it long enough
    fetch_wins = bus.if_req & (~data_req | (32'(streak_q) >= MAX_STREAK));

    unique case (state_q)
      IDLE: begin
        if (fetch_wins) begin
          owner_d  = OWN_IF;
          wr_d     = 1'b0;
          addr_d   = {bus.if_addr[DATA_W-1:2], 2'b00};
          wdata_d  = '0;
          streak_d = '0;
          cnt_d    = CNT_W'(LATENCY - 1);
          state_d  = BUSY;
          mem_en_d = 1'b1;
        end else if (data_req) begin
          owner_d  = OWN_DM;
          // Simultaneous load+store is serviced as a store and flagged
          wr_d     = bus.dm_wr;
          addr_d   = {bus.dm_addr[DATA_W-1:2], 2'b00};
          wdata_d  = bus.dm_wdata;
          perr_d   = perr_q | (bus.dm_rd & bus.dm_wr);
          if (bus.if_req) begin
            streak_d = (streak_q == {CNT_W{1'b1}}) ? streak_q : streak_q + CNT_W'(1);
          end else begin
            streak_d = '0;
          end
          cnt_d    = CNT_W'(LATENCY - 1);
          state_d  = BUSY;
          mem_en_d = 1'b1;
          mem_we_d = bus.dm_wr;
        end
      end

      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!wr_q) begin
            if (owner_q == OWN_IF) begin
              if_rdata_d = bus.mem_rdata;
            end else begin
              dm_rdata_d = bus.mem_rdata;
            end
          end
          if_ready_d = (owner_q == OWN_IF);
          dm_ready_d = (owner_q == OWN_DM);
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          mem_en_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_en       = mem_en_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.if_ready     = if_ready_q;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.dm_ready     = dm_ready_q;
  assign bus.dm_rdata     = dm_rdata_q;
  assign bus.protocol_err = perr_q;

  // Requester stalls are combinational so they drop in the ready cycle
  assign bus.stall_if  = bus.if_req & ~if_ready_q;
  assign bus.stall_mem = (bus.dm_rd | bus.dm_wr) & ~dm_ready_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized requesters, checked every
// cycle against a transaction-timeline model of the arbiter.
module tb_mem_arbiter;
  localparam int unsigned L  = 2;
  localparam int unsigned MS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.LATENCY(L), .MAX_STREAK(MS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Memory contents as a pure function of the word address
  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h8C08_0004;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // Read data is only valid on the LATENCY-th consecutive enabled cycle
  int en_cnt = 0;
  always @(posedge clk) en_cnt <= bus.mem_en ? en_cnt + 1 : 0;
  assign bus.mem_rdata = (bus.mem_en && en_cnt == int'(L) - 1) ? memfn(bus.mem_addr)
                                                               : 32'hBAD0_BAD0;

  // ---------------- reference model: one transaction on a timeline ----------
  // A grant decided at the end of cycle g occupies the memory for cycles
  // g+1..g+L, pulses ready at g+L+1, and the next arbitration ends cycle g+L+2.
  bit          model_en = 1'b0;
  bit          have = 1'b0;
  int          g = 0;
  bit          t_dm, t_wr;
  logic [31:0] t_addr, t_wdata;
  int          streak_m = 0;
  bit          perr_m = 1'b0;
  logic [31:0] if_rd_m = '0, dm_rd_m = '0;

  always @(posedge clk) begin
    if (reset) begin
      have = 1'b0; streak_m = 0; perr_m = 1'b0;
      if_rd_m = '0; dm_rd_m = '0; model_en = 1'b1;
    end else begin
      if (have && cyc == g + int'(L) && !t_wr) begin
        if (t_dm) dm_rd_m = memfn(t_addr);
        else      if_rd_m = memfn(t_addr);
      end
      if (!have || cyc >= g + int'(L) + 2) begin
        if (bus.if_req && (!(bus.dm_rd || bus.dm_wr) || streak_m >= int'(MS))) begin
          have = 1'b1; g = cyc; t_dm = 1'b0; t_wr = 1'b0;
          t_addr = {bus.if_addr[31:2], 2'b00}; t_wdata = '0;
          streak_m = 0;
        end else if (bus.dm_rd || bus.dm_wr) begin
          have = 1'b1; g = cyc; t_dm = 1'b1; t_wr = bus.dm_wr;
          t_addr = {bus.dm_addr[31:2], 2'b00}; t_wdata = bus.dm_wdata;
          if (bus.dm_rd && bus.dm_wr) perr_m = 1'b1;
          streak_m = bus.if_req ? ((streak_m < 15) ? streak_m + 1 : 15) : 0;
        end
      end
    end
    cyc = cyc + 1;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (model_en) begin
      bit busy, ir, dr;
      busy = have && cyc >= g + 1 && cyc <= g + int'(L);
      ir   = have && cyc == g + int'(L) + 1 && !t_dm;
      dr   = have && cyc == g + int'(L) + 1 && t_dm;
      chk("mem_en",     32'(bus.mem_en),   32'(busy));
      chk("mem_we",     32'(bus.mem_we),   32'(have && t_wr && cyc == g + 1));
      if (busy) chk("mem_addr", bus.mem_addr, t_addr);
      if (busy && t_wr) chk("mem_wdata", bus.mem_wdata, t_wdata);
      chk("if_ready",   32'(bus.if_ready), 32'(ir));
      chk("dm_ready",   32'(bus.dm_ready), 32'(dr));
      chk("if_rdata",   bus.if_rdata,      if_rd_m);
      chk("dm_rdata",   bus.dm_rdata,      dm_rd_m);
      chk("protocol_err", 32'(bus.protocol_err), 32'(perr_m));
      chk("stall_if",   32'(bus.stall_if), 32'(bus.if_req & ~ir));
      chk("stall_mem",  32'(bus.stall_mem), 32'((bus.dm_rd | bus.dm_wr) & ~dr));
      chk("ready_excl", 32'(bus.if_ready & bus.dm_ready), 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_in();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_rd = 1'b0; bus.dm_wr = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
  endtask

  task automatic dm_pick(input bit allow_idle);
    int r;
    r = $urandom_range(0, 47);
    bus.dm_addr  = $urandom;
    bus.dm_wdata = $urandom;
    if (allow_idle && r >= 32) begin
      bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
    end else if (r == 0) begin
      bus.dm_rd = 1'b1; bus.dm_wr = 1'b1;
    end else if (r < 12) begin
      bus.dm_rd = 1'b0; bus.dm_wr = 1'b1;
    end else begin
      bus.dm_rd = 1'b1; bus.dm_wr = 1'b0;
    end
  endtask

  string seq;

  initial begin
    reset = 1'b1;
    clear_in();
    tick(2);
    chk("rst_mem_en",   32'(bus.mem_en), 32'd0);
    chk("rst_mem_we",   32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_if_ready", 32'(bus.if_ready), 32'd0);
    chk("rst_dm_ready", 32'(bus.dm_ready), 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
    chk("rst_perr",     32'(bus.protocol_err), 32'd0);
    reset = 1'b0;
    tick(2);

    // Single fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h0040_0000;
    #1 chk("f_stall_T", 32'(bus.stall_if), 32'd1);
    tick(1);
    chk("f_en_T1",   32'(bus.mem_en), 32'd1);
    chk("f_addr_T1", bus.mem_addr, 32'h0040_0000);
    chk("f_stall_T1", 32'(bus.stall_if), 32'd1);
    tick(1);
    chk("f_en_T2",    32'(bus.mem_en), 32'd1);
    chk("f_rdy_T2",   32'(bus.if_ready), 32'd0);
    chk("f_stall_T2", 32'(bus.stall_if), 32'd1);
    tick(1);
    chk("f_rdy_T3",   32'(bus.if_ready), 32'd1);
    chk("f_rdata_T3", bus.if_rdata, 32'h8C08_0004);
    chk("f_en_T3",    32'(bus.mem_en), 32'd0);
    chk("f_stall_T3", 32'(bus.stall_if), 32'd0);
    bus.if_req = 1'b0;
    tick(1);
    chk("f_rdy_T4", 32'(bus.if_ready), 32'd0);

    // Simultaneous fetch and load: data first
    bus.if_req = 1'b1; bus.if_addr = 32'h0040_0100;
    bus.dm_rd  = 1'b1; bus.dm_addr = 32'h1001_0000;
    tick(3);
    chk("s_dmrdy_T3", 32'(bus.dm_ready), 32'd1);
    chk("s_ifrdy_T3", 32'(bus.if_ready), 32'd0);
    chk("s_dmrd_T3",  bus.dm_rdata, 32'h5A5A_0235);
    bus.dm_rd = 1'b0;
    tick(1);
    chk("s_en_T4", 32'(bus.mem_en), 32'd0);
    tick(1);
    chk("s_en_T5",   32'(bus.mem_en), 32'd1);
    chk("s_addr_T5", bus.mem_addr, 32'h0040_0100);
    tick(2);
    chk("s_ifrdy_T7", 32'(bus.if_ready), 32'd1);
    chk("s_ifrd_T7",  bus.if_rdata, 32'h5B5A_1274);
    bus.if_req = 1'b0;
    tick(1);

    // Starvation guard: fetch and load held high together
    bus.if_req = 1'b1; bus.if_addr = 32'h0040_0000;
    bus.dm_rd  = 1'b1; bus.dm_addr = 32'h1001_0000;
    seq = "";
    for (int k = 0; k < 80 && seq.len() < 6; k++) begin
      tick(1);
      if (bus.dm_ready) seq = {seq, "D"};
      if (bus.if_ready) seq = {seq, "F"};
    end
    checks++;
    if (seq != "DDDDFD") begin
      errors++;
      $display("FAIL starvation_order: got '%s' expected 'DDDDFD'", seq);
    end
    clear_in();
    tick(6);

    // Store: aligned address, one-cycle write, load data untouched
    bus.dm_wr = 1'b1; bus.dm_addr = 32'h1001_0003; bus.dm_wdata = 32'hDEAD_BEEF;
    tick(1);
    chk("w_we_T1",    32'(bus.mem_we), 32'd1);
    chk("w_addr_T1",  bus.mem_addr, 32'h1001_0000);
    chk("w_wdata_T1", bus.mem_wdata, 32'hDEAD_BEEF);
    tick(1);
    chk("w_we_T2", 32'(bus.mem_we), 32'd0);
    chk("w_en_T2", 32'(bus.mem_en), 32'd1);
    tick(1);
    chk("w_rdy_T3",  32'(bus.dm_ready), 32'd1);
    chk("w_rdata_T3", bus.dm_rdata, 32'h5A5A_0235);
    bus.dm_wr = 1'b0;
    tick(1);

    // Load+store collision, then reset in the second busy cycle
    bus.dm_rd = 1'b1; bus.dm_wr = 1'b1;
    bus.dm_addr = 32'h1001_0008; bus.dm_wdata = 32'h1234_5678;
    tick(1);
    chk("e_we_T1",   32'(bus.mem_we), 32'd1);
    chk("e_perr_T1", 32'(bus.protocol_err), 32'd1);
    tick(1);
    chk("e_perr_T2", 32'(bus.protocol_err), 32'd1);
    chk("e_en_T2",   32'(bus.mem_en), 32'd1);
    reset = 1'b1;
    clear_in();
    tick(1);
    chk("e_en_T3",   32'(bus.mem_en), 32'd0);
    chk("e_perr_T3", 32'(bus.protocol_err), 32'd0);
    chk("e_rdy_T3",  32'(bus.dm_ready), 32'd0);
    reset = 1'b0;
    tick(1);
    chk("e_rdy_T4", 32'(bus.dm_ready), 32'd0);
    chk("e_en_T4",  32'(bus.mem_en), 32'd0);

    // Randomized requesters
    for (int k = 0; k < 4000; k++) begin
      tick(1);
      reset = ($urandom_range(0, 499) == 0);
      if (bus.if_req) begin
        if (bus.if_ready) begin
          bus.if_req  = ($urandom_range(0, 2) != 0);
          bus.if_addr = $urandom;
        end else if ($urandom_range(0, 99) == 0) begin
          bus.if_req = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bus.if_req  = 1'b1;
        bus.if_addr = $urandom;
      end
      if (bus.dm_rd || bus.dm_wr) begin
        if (bus.dm_ready) dm_pick(1'b1);
        else if ($urandom_range(0, 99) == 0) begin
          bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        dm_pick(1'b0);
      end
    end
    reset = 1'b0;
    clear_in();
    tick(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
